alu_muldiv_unit: RTL and testbench
==================================

// Module: alu_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide execution unit; consumes the ALU operation code produced by
//  alu_control and returns the result to writeback over a valid/ready handshake.
//  Sits beside the single-cycle ALU in EX; the pipeline stalls while ready_w_o is low.
//  Radix-2 shift-add multiply and restoring divide, one bit per clock.
// PARAMETERS
//  WIDTH     32  operand/result width in bits (>=8, even)
//  CNT_W     6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk_w_i           in   1      system clock, rising edge
//  rst_n_w_i         in   1      asynchronous active-low reset
//  start_w_i         in   1      request valid; accepted when start_w_i & ready_w_o
//  op_w_i            in   3      [1:0] 00 MUL, 01 MULH, 10 DIV, 11 REM; [2] signed
//  a_w_i             in   WIDTH  operand A (multiplicand / dividend)
//  b_w_i             in   WIDTH  operand B (multiplier / divisor)
//  ready_w_o         out  1      unit idle, can accept a request
//  result_valid_w_o  out  1      result_w_o valid; held until consumed
//  result_ready_w_i  in   1      consumer accepts result this cycle
//  result_w_o        out  WIDTH  MUL low half / MULH high half / quotient / remainder
//  div_zero_w_o      out  1      qualifies result: divisor was zero (DIV/REM only)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, ready_w_o=1, result_valid_w_o=0,
//   result_w_o=0, div_zero_w_o=0, counter=0.
//  FSM IDLE -> BUSY on accept; operands/op captured into internal registers on that edge.
//  BUSY: WIDTH iterations, counter WIDTH-1 down to 0; BUSY -> DONE when counter==0.
//  DONE: result_valid_w_o=1, result_w_o/div_zero_w_o stable; DONE -> IDLE on result_ready_w_i.
//  Latency: accept at edge N -> result_valid_w_o high after edge N+WIDTH+1 (33 clocks at 32).
//  ready_w_o high only in IDLE; start_w_i ignored in BUSY/DONE (no queuing, no abort).
//  result_ready_w_i in IDLE/BUSY is ignored. Result is not overwritten while unconsumed.
//  MUL: 2*WIDTH product accumulator; MUL returns [WIDTH-1:0], MULH returns [2W-1:W].
//  DIV/REM: restoring, WIDTH+1-bit partial remainder; quotient shifted in LSB-first register.
//  Divide by zero: no iteration shortcut, same latency; quotient = all ones,
//   remainder = dividend, div_zero_w_o=1.
//  Reset mid-BUSY or mid-DONE: immediate return to reset values; pending result discarded.
// CONFIGURATION
//  ALU_MULDIV_SIGNED_EN defined: op[2]=1 -> two's-complement operation. Operands are
//   abs-converted at accept; result sign-corrected on BUSY->DONE edge (latency unchanged).
//   Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//   Overflow -2**(W-1) / -1: quotient = -2**(W-1), remainder = 0, div_zero_w_o=0.
//   Divide by zero result is not sign-corrected (all ones / raw dividend).
//  Not defined: op[2] ignored, every operation unsigned; sign-correction logic absent.
// STRUCTURE
//  Shared package alu_pkg: op encodings (MD_MUL, MD_MULH, MD_DIV, MD_REM, MD_SIGNED_BIT),
//   FSM state encodings (MD_IDLE, MD_BUSY, MD_DONE); also used by alu_control and decode.
//  One sub-module: alu_muldiv_datapath (accumulator/remainder shift registers, add/subtract,
//   per-iteration step enable); alu_muldiv_unit keeps FSM, counter, handshake, sign fix-up.
// TESTING (WIDTH=32)
//  MUL a=7 b=6 -> result_valid_w_o high 33 clocks after accept, result 42, div_zero_w_o 0.
//  MULH a=b=0xFFFFFFFF op=001 -> 0xFFFFFFFE; with macro op=101 -> 0x00000000.
//  DIV 100/7 -> 14; REM 100/7 -> 2; with macro DIV -100/7 (op=110) -> 0xFFFFFFF2 (-14).
//  DIV 5/0 -> 0xFFFFFFFF, div_zero_w_o=1; REM 5/0 -> 5, div_zero_w_o=1.
//  Backpressure: result_ready_w_i low 10 clocks in DONE -> result stable, ready_w_o 0,
//   start_w_i pulses ignored; ready_w_o returns 1 the clock after consumption.
//  rst_n_w_i low at iteration 16 of DIV -> outputs to reset values at once; new MUL 3*3
//   after release -> 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: multiply/divide op codes and the muldiv FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULH = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_REM  = 2'b11;

    localparam int MD_SIGNED_BIT = 2;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_datapath.sv
// Shared shift register pair for radix-2 shift-add multiply and restoring divide.
// hi/lo hold product halves (multiply) or partial remainder / dividend-quotient (divide).
module alu_muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk_w_i,
    input  logic             rst_n_w_i,
    input  logic             load_w_i,
    input  logic             step_w_i,
    input  logic             is_div_w_i,
    input  logic [WIDTH-1:0] a_w_i,
    input  logic [WIDTH-1:0] b_w_i,
    output logic [WIDTH-1:0] hi_next_w_o,
    output logic [WIDTH-1:0] lo_next_w_o
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic             w_unused_diff_msb;

    // The accepted remainder is always below the divisor, so it fits in WIDTH bits.
    assign w_unused_diff_msb = w_diff[WIDTH];

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_trial = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_m};
        w_ge    = (w_trial >= {1'b0, r_m});
        if (is_div_w_i) begin
            hi_next_w_o = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            lo_next_w_o = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            hi_next_w_o = w_sum[WIDTH:1];
            lo_next_w_o = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) begin
            r_hi <= '0;
            r_lo <= '0;
            r_m  <= '0;
        end else if (load_w_i) begin
            r_hi <= '0;
            r_lo <= is_div_w_i ? a_w_i : b_w_i;
            r_m  <= is_div_w_i ? b_w_i : a_w_i;
        end else if (step_w_i) begin
            r_hi <= hi_next_w_o;
            r_lo <= lo_next_w_o;
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle multiply/divide unit with valid/ready result handshake.
// Define ALU_MULDIV_SIGNED_EN to honour op[2] as a two's-complement request.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_w_i,
    input  logic             rst_n_w_i,
    input  logic             start_w_i,
    input  logic [2:0]       op_w_i,
    input  logic [WIDTH-1:0] a_w_i,
    input  logic [WIDTH-1:0] b_w_i,
    output logic             ready_w_o,
    output logic             result_valid_w_o,
    input  logic             result_ready_w_i,
    output logic [WIDTH-1:0] result_w_o,
    output logic             div_zero_w_o
);

    md_state_e          r_state;
    md_state_e          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_dz;
    logic               r_load;
    logic [WIDTH-1:0]   r_result;
    logic               r_div_zero;
    logic               r_valid;

    logic               w_accept;
    logic               w_dp_load;
    logic               w_dp_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_result;

`ifdef ALU_MULDIV_SIGNED_EN
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               r_neg_ab;
    logic               r_neg_a;

    assign w_signed = op_w_i[MD_SIGNED_BIT];
    assign w_a_neg  = w_signed & a_w_i[WIDTH-1];
    assign w_b_neg  = w_signed & b_w_i[WIDTH-1];
    assign w_a_abs  = w_a_neg ? (~a_w_i + 1'b1) : a_w_i;
    assign w_b_abs  = w_b_neg ? (~b_w_i + 1'b1) : b_w_i;

    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) begin
            r_neg_ab <= 1'b0;
            r_neg_a  <= 1'b0;
        end else if (w_accept) begin
            r_neg_ab <= w_a_neg ^ w_b_neg;
            r_neg_a  <= w_a_neg;
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = op_w_i[MD_SIGNED_BIT];
    assign w_a_abs       = a_w_i;
    assign w_b_abs       = b_w_i;
`endif

    assign ready_w_o        = (r_state == MD_IDLE);
    assign result_valid_w_o = r_valid;
    assign result_w_o       = r_result;
    assign div_zero_w_o     = r_div_zero;

    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One load cycle precedes the WIDTH shift steps, giving WIDTH+1 busy clocks.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_dp_load    = 1'b0;
        w_dp_step    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (start_w_i) begin
                    w_accept     = 1'b1;
                    w_state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (r_load) begin
                    w_dp_load = 1'b1;
                end else begin
                    w_dp_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_last       = 1'b1;
                        w_state_next = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                if (result_ready_w_i) begin
                    w_state_next = MD_IDLE;
                end
            end
            default: w_state_next = MD_IDLE;
        endcase
    end

    alu_muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk_w_i     (clk_w_i),
        .rst_n_w_i   (rst_n_w_i),
        .load_w_i    (w_dp_load),
        .step_w_i    (w_dp_step),
        .is_div_w_i  (md_is_div(r_op)),
        .a_w_i       (r_a),
        .b_w_i       (r_b),
        .hi_next_w_o (w_hi_next),
        .lo_next_w_o (w_lo_next)
    );

    // Result is taken from the final step's next value so it lands on the BUSY->DONE edge.
    always_comb begin
        w_prod = {w_hi_next, w_lo_next};
        w_quot = w_lo_next;
        w_rem  = w_hi_next;
`ifdef ALU_MULDIV_SIGNED_EN
        if (r_neg_ab) begin
            w_prod = ~w_prod + 1'b1;
        end
        if (r_neg_ab && !r_dz) begin
            w_quot = ~w_quot + 1'b1;
        end
        // On divide by zero this restores the raw dividend from its magnitude.
        if (r_neg_a) begin
            w_rem = ~w_rem + 1'b1;
        end
`endif
        case (r_op)
            MD_MUL:  w_result = w_prod[WIDTH-1:0];
            MD_MULH: w_result = w_prod[2*WIDTH-1:WIDTH];
            MD_DIV:  w_result = w_quot;
            MD_REM:  w_result = w_rem;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
        if (!rst_n_w_i) begin
            r_cnt      <= '0;
            r_op       <= MD_MUL;
            r_a        <= '0;
            r_b        <= '0;
            r_dz       <= 1'b0;
            r_load     <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= op_w_i[1:0];
                r_a    <= w_a_abs;
                r_b    <= w_b_abs;
                r_dz   <= md_is_div(op_w_i[1:0]) && (b_w_i == '0);
                r_load <= 1'b1;
                r_cnt  <= CNT_W'(WIDTH - 1);
            end
            if (w_dp_load) begin
                r_load <= 1'b0;
            end
            if (w_dp_step && !w_last) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                r_result   <= w_result;
                r_div_zero <= r_dz;
                r_valid    <= 1'b1;
            end
            if (r_state == MD_DONE && result_ready_w_i) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed-vector bench for alu_muldiv_unit at WIDTH=32; signed vectors follow ALU_MULDIV_SIGNED_EN.
module tb_alu_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         div_zero;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk_w_i          (clk),
        .rst_n_w_i        (rst_n),
        .start_w_i        (start),
        .op_w_i           (op),
        .a_w_i            (a),
        .b_w_i            (b),
        .ready_w_o        (ready),
        .result_valid_w_o (res_valid),
        .result_ready_w_i (res_ready),
        .result_w_o       (result),
        .div_zero_w_o     (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!res_valid) begin
            chk({tag, " valid timeout"}, 64'(res_valid), 64'd1);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_res, input logic exp_dz);
        int cyc;
        chk({tag, " ready"}, 64'(ready), 64'd1);
        issue(o, x, y);
        wait_valid(tag, cyc);
        chk({tag, " latency"}, 64'(cyc), 64'd33);
        chk({tag, " result"}, 64'(result), 64'(exp_res));
        chk({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        $display("%s op=%b a=%h b=%h -> %h dz=%b lat=%0d", tag, o, x, y, result, div_zero, cyc);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({tag, " ready after consume"}, 64'(ready), 64'd1);
        chk({tag, " valid after consume"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset valid", 64'(res_valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset div_zero", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("MUL 7*6", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0);
        run_op("MULH ffffffff^2", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
`ifdef ALU_MULDIV_SIGNED_EN
        run_op("MULHS -1*-1", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("DIVS -100/7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        run_op("DIVS ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("REMS ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("DIVS -5/0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
`else
        run_op("MULH op101", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("DIV op110", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 1'b0);
        run_op("DIV 80000000/ffffffff", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("REM 80000000/ffffffff", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
`endif
        run_op("REM -5/0", 3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
        run_op("DIV 100/7", 3'b010, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("REM 100/7", 3'b011, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("DIV 5/0", 3'b010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("REM 5/0", 3'b011, 32'd5, 32'd0, 32'd5, 1'b1);

        // Backpressure: result held while unconsumed, new starts ignored.
        issue(3'b000, 32'd5, 32'd5);
        wait_valid("BP", cyc);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            op    = 3'b000;
            a     = 32'd100 + 32'(i);
            b     = 32'd3;
            @(posedge clk);
            #1;
            chk("BP result held", 64'(result), 64'd25);
            chk("BP ready low", 64'(ready), 64'd0);
            chk("BP valid held", 64'(res_valid), 64'd1);
        end
        start = 1'b0;
        $display("BP MUL 5*5 held 10 clocks -> %h", result);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("BP ready after consume", 64'(ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("BP nothing queued ready", 64'(ready), 64'd1);
        chk("BP nothing queued valid", 64'(res_valid), 64'd0);

        // Reset in the middle of a divide.
        issue(3'b010, 32'd1000, 32'd3);
        repeat (17) @(posedge clk);
        #1;
        chk("RST busy before", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("RST ready", 64'(ready), 64'd1);
        chk("RST valid", 64'(res_valid), 64'd0);
        chk("RST result", 64'(result), 64'd0);
        chk("RST div_zero", 64'(div_zero), 64'd0);
        $display("RST mid-DIV -> ready=%b valid=%b result=%h", ready, res_valid, result);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("MUL 3*3 after reset", 3'b000, 32'd3, 32'd3, 32'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
